// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striper / unstriper pair: width codes, byte counts, state encoding.
package byte_striping_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WCODE_W = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned NB_W    = 3;

    localparam logic [WCODE_W-1:0] W8A = 2'b00;
    localparam logic [WCODE_W-1:0] W16 = 2'b01;
    localparam logic [WCODE_W-1:0] W32 = 2'b10;
    localparam logic [WCODE_W-1:0] W8B = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of bytes carried by a word of the given width code.
    function automatic logic [NB_W-1:0] bytes_for_width(input logic [WCODE_W-1:0] s);
        logic [NB_W-1:0] n;
        case (s)
            W16:     n = 3'd2;
            W32:     n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/byte_shift_out.sv
// 32-bit load/shift register that presents a word one byte at a time in MSB- or LSB-first order.
module byte_shift_out
    import byte_striping_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk8,
    input  logic                reset,
    input  logic                enb,
    input  logic                load,
    input  logic                shift,
    input  logic [WCODE_W-1:0]  width,
    input  logic [WORD_W-1:0]   din,
    output logic [BYTE_W-1:0]   first_byte_c,
    output logic [BYTE_W-1:0]   next_byte_c
);

    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] aligned_c;

    // Align the offered word so its first byte sits at the output end of the register.
    always_comb begin
        aligned_c = '0;
        case (width)
            W16:     aligned_c = MSB_FIRST ? {din[15:0], 16'h0000} : {16'h0000, din[15:0]};
            W32:     aligned_c = din;
            default: aligned_c = MSB_FIRST ? {din[7:0], 24'h000000} : {24'h000000, din[7:0]};
        endcase
        first_byte_c = MSB_FIRST ? aligned_c[31:24] : aligned_c[7:0];
        next_byte_c  = MSB_FIRST ? sreg[31:24] : sreg[7:0];
    end

    // Hold the bytes still to be sent; the first byte goes straight to the output on load.
    always_ff @(posedge clk8) begin
        if (reset) begin
            sreg <= '0;
        end else if (enb) begin
            if (load) begin
                sreg <= MSB_FIRST ? (aligned_c << 8) : (aligned_c >> 8);
            end else if (shift) begin
                sreg <= MSB_FIRST ? (sreg << 8) : (sreg >> 8);
            end
        end
    end

endmodule

// File: rtl/byte_striping.sv
// Serializes 8/16/32-bit words onto an 8-bit lane with byte index and last-byte flag.
module byte_striping
    import byte_striping_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                clk8,
    input  logic                reset,
    input  logic                enb,
    input  logic [WCODE_W-1:0]  S,
    input  logic [WORD_W-1:0]   entrada,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BYTE_W-1:0]   salida,
    output logic                out_valid,
    output logic [CNT_W-1:0]    contador,
    output logic                ultimo,
    output logic [WCODE_W-1:0]  internoS
);

    state_t            state;
    logic [CNT_W-1:0]  remaining;
    logic              accept_c;
    logic              shift_c;
    logic [NB_W-1:0]   nbytes_c;
    logic [BYTE_W-1:0] first_byte_c;
    logic [BYTE_W-1:0] next_byte_c;

    // A new word is taken only when nothing is left to send behind the current byte.
    assign in_ready = ~reset & enb & (remaining == 2'd0);
    assign accept_c = in_valid & in_ready;
    assign shift_c  = ~accept_c & (remaining != 2'd0);
    assign nbytes_c = bytes_for_width(S);

    byte_shift_out #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk8         (clk8),
        .reset        (reset),
        .enb          (enb),
        .load         (accept_c),
        .shift        (shift_c),
        .width        (S),
        .din          (entrada),
        .first_byte_c (first_byte_c),
        .next_byte_c  (next_byte_c)
    );

    // Word sequencing: load on accept, step one byte per enabled edge, drop to idle when drained.
    always_ff @(posedge clk8) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            salida    <= IDLE_BYTE;
            out_valid <= 1'b0;
            contador  <= '0;
            ultimo    <= 1'b0;
            internoS  <= W8A;
        end else if (enb) begin
            if (accept_c) begin
                state     <= SEND;
                salida    <= first_byte_c;
                out_valid <= 1'b1;
                contador  <= '0;
                ultimo    <= (nbytes_c == 3'd1);
                internoS  <= S;
                remaining <= CNT_W'(nbytes_c - 3'd1);
            end else if (remaining != 2'd0) begin
                salida    <= next_byte_c;
                contador  <= contador + 2'd1;
                remaining <= remaining - 2'd1;
                ultimo    <= (remaining == 2'd1);
            end else if (state == SEND) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                ultimo    <= 1'b0;
                contador  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_byte_striping.sv
// Randomized + directed scoreboard bench for byte_striping.
module tb_byte_striping;

    logic        clk8 = 1'b0;
    logic        reset;
    logic        enb;
    logic [1:0]  S;
    logic [31:0] entrada;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  salida;
    logic        out_valid;
    logic [1:0]  contador;
    logic        ultimo;
    logic [1:0]  internoS;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] b;
        logic [1:0] idx;
        logic       last;
        logic [1:0] s;
    } rec_t;

    rec_t exp_q[$];

    byte_striping dut (
        .clk8      (clk8),
        .reset     (reset),
        .enb       (enb),
        .S         (S),
        .entrada   (entrada),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .salida    (salida),
        .out_valid (out_valid),
        .contador  (contador),
        .ultimo    (ultimo),
        .internoS  (internoS)
    );

    always #5 clk8 = ~clk8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; on an expected accept, push the word's bytes into the scoreboard.
    task automatic cyc(input logic r, input logic e, input logic v,
                       input logic [1:0] s, input logic [31:0] d);
        int   n;
        logic exp_rdy;
        rec_t rc;
        @(negedge clk8);
        reset    = r;
        enb      = e;
        in_valid = v;
        S        = s;
        entrada  = d;
        if (r) exp_q.delete();
        #1;
        exp_rdy = !r && e && (exp_q.size() == 0);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            n = (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 1;
            for (int k = 0; k < n; k++) begin
                rc.b    = 8'(d >> (8 * (n - 1 - k)));
                rc.idx  = 2'(k);
                rc.last = (k == n - 1);
                rc.s    = s;
                exp_q.push_back(rc);
            end
        end
    endtask

    // Monitor: model the output registers from the scoreboard and compare every cycle.
    initial begin
        logic [7:0] m_sal;
        logic       m_val;
        logic [1:0] m_cnt;
        logic       m_last;
        logic [1:0] m_ints;
        logic       r_s, e_s;
        rec_t       rc;
        m_sal = 8'h00; m_val = 1'b0; m_cnt = 2'd0; m_last = 1'b0; m_ints = 2'd0;
        forever begin
            @(posedge clk8);
            r_s = reset;
            e_s = enb;
            #1;
            if (r_s) begin
                m_sal = 8'h00; m_val = 1'b0; m_cnt = 2'd0; m_last = 1'b0; m_ints = 2'd0;
            end else if (e_s) begin
                if (exp_q.size() != 0) begin
                    rc     = exp_q.pop_front();
                    m_sal  = rc.b;
                    m_val  = 1'b1;
                    m_cnt  = rc.idx;
                    m_last = rc.last;
                    m_ints = rc.s;
                end else begin
                    m_val  = 1'b0;
                    m_cnt  = 2'd0;
                    m_last = 1'b0;
                end
            end
            chk("out_valid", 32'(out_valid), 32'(m_val));
            chk("salida",    32'(salida),    32'(m_sal));
            chk("contador",  32'(contador),  32'(m_cnt));
            chk("ultimo",    32'(ultimo),    32'(m_last));
            chk("internoS",  32'(internoS),  32'(m_ints));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enb = 1'b1; in_valid = 1'b0; S = 2'b00; entrada = '0;
        cyc(1, 1, 0, 2'b00, 32'h0);
        cyc(1, 1, 0, 2'b00, 32'h0);
        // reset mid-word after two bytes
        cyc(0, 1, 1, 2'b10, 32'h11223344);
        cyc(0, 1, 0, 2'b10, 32'h0);
        cyc(1, 1, 0, 2'b10, 32'h0);
        cyc(0, 1, 0, 2'b10, 32'h0);
        cyc(0, 1, 0, 2'b10, 32'h0);
        // 32-bit single word
        cyc(0, 1, 1, 2'b10, 32'hDEADBEEF);
        repeat (5) cyc(0, 1, 0, 2'b10, 32'h0);
        // 16-bit back-to-back with in_valid held
        cyc(0, 1, 1, 2'b01, 32'h00001234);
        cyc(0, 1, 1, 2'b01, 32'h0000ABCD);
        cyc(0, 1, 1, 2'b01, 32'h0000ABCD);
        cyc(0, 1, 0, 2'b01, 32'h0);
        cyc(0, 1, 0, 2'b01, 32'h0);
        // 8-bit modes held valid
        cyc(0, 1, 1, 2'b00, 32'h0000005A);
        cyc(0, 1, 1, 2'b11, 32'h000000C3);
        cyc(0, 1, 0, 2'b11, 32'h0);
        // width change mid-word is ignored
        cyc(0, 1, 1, 2'b10, 32'h01020304);
        repeat (4) cyc(0, 1, 0, 2'b01, 32'hFFFFFFFF);
        // enable stall after the second byte
        cyc(0, 1, 1, 2'b10, 32'hA1B2C3D4);
        cyc(0, 1, 0, 2'b10, 32'h0);
        repeat (3) cyc(0, 0, 1, 2'b10, 32'h55555555);
        repeat (4) cyc(0, 1, 0, 2'b10, 32'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), $urandom);
        end
        repeat (6) cyc(0, 1, 0, 2'b00, 32'h0);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- Transmit-side counterpart of the byte unstriper.
- Accepts one 8-, 16- or 32-bit word per transfer and serializes it onto an 8-bit lane, one byte per clk8 cycle, most-significant byte first, with a valid-ready input handshake.
- Emits a byte index (contador) and a last-byte flag so the unstriper can reassemble the word.
- Sits between the link-layer word source and the per-lane byte path.

Parameters:
- MSB_FIRST, 1, 1 = byte order [31:24]..[7:0] (32-bit) / [15:8],[7:0] (16-bit); 0 = reversed order.
- IDLE_BYTE, 8'h00, value driven on salida while out_valid=0 after reset.

Ports:
- clk8  input  1  byte clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- enb  input  1  global enable; 0 freezes all state.
- S  input  2  word width for the offered word: 00/11 = 8 bits, 01 = 16 bits, 10 = 32 bits.
- entrada  input  32  offered word; 8-bit mode uses [7:0], 16-bit mode uses [15:0].
- in_valid  input  1  entrada/S are valid.
- in_ready  output  1  block accepts a word this cycle (combinational).
- salida  output  8  serialized byte (registered).
- out_valid  output  1  salida holds a valid byte (registered).
- contador  output  2  index of the byte on salida within its word, 0 = first.
- ultimo  output  1  salida is the final byte of its word.
- internoS  output  2  latched width code of the word being sent.

Behaviour:
- Reset (synchronous, active-high, clock clk8) values:
  - salida = IDLE_BYTE; out_valid = 0; contador = 0; ultimo = 0; internoS = 2'b00.
  - Internal shift register = 0; remaining count = 0; state = IDLE.
  - Reset overrides enb and aborts any word mid-transfer; partial bytes are dropped.
- Handshake: in_ready = ~reset & enb & (remaining == 0). A word is accepted on an edge where in_valid & in_ready.
- States:
  - IDLE: remaining == 0 and out_valid == 0.
  - SEND: bytes pending or on salida.
- Accept edge:
  - N = 1/2/4 for S = 00|11 / 01 / 10.
  - salida = first byte: entrada[7:0] for 8-bit; [15:8] for 16-bit; [31:24] for 32-bit (MSB_FIRST=1).
  - out_valid = 1; contador = 0; ultimo = (N == 1); internoS = S.
  - remaining = N-1; the remaining bytes are stored in the shift register.
- Each subsequent enabled edge with remaining > 0:
  - salida = next byte; contador += 1; remaining -= 1; ultimo = (remaining becomes 0).
- Latency: first byte appears on salida 1 cycle after the accept edge. A word takes N cycles.
- Back-to-back words: in_ready rises in the cycle where the last byte (ultimo=1) is on salida. A word accepted then produces its first byte on the next edge with no bubble.
- Edge with remaining == 0 and no accept:
  - out_valid = 0; ultimo = 0; contador = 0.
  - salida holds its last value; return to IDLE.
- Width control: S and entrada are sampled only on the accept edge. Changes mid-word are ignored; internoS keeps the latched width until the next accept.
- enb = 0: no state changes, in_ready = 0, outputs hold. Resuming continues from the same byte.
- contador wraps implicitly: its maximum is 3 (32-bit), and it returns to 0 on every accept.
- No downstream backpressure: the consumer takes one byte per clk8 while out_valid = 1.

Decomposition:
- Shared package (shared with the unstriper):
  - width codes: W8A = 2'b00, W16 = 2'b01, W32 = 2'b10, W8B = 2'b11;
  - function bytes_for_width(S) returning 1/2/4;
  - state encoding IDLE/SEND.
- One natural sub-module: byte_shift_out, a 32-bit load/shift register with byte select and MSB_FIRST ordering, used by byte_striping.
- Handshake and counter logic stay in the top module.

Test Plan:
- Reset mid-word: accept 32-bit word, reset after 2 bytes → next edge out_valid=0, salida=8'h00, in_ready=1 after reset deasserts, and no remaining bytes are emitted.
- 32-bit single word: S=10, entrada=32'hDEADBEEF, one-cycle in_valid → salida DE,AD,BE,EF on 4 consecutive cycles, contador 0,1,2,3, ultimo only on EF, then out_valid=0.
- 16-bit back-to-back: S=01, words 16'h1234 then 16'hABCD, in_valid held → salida 12,34,AB,CD with no gap; in_ready high only in the 34 and CD cycles.
- 8-bit modes: S=00 with 8'h5A, then S=11 with 8'hC3, held valid → salida 5A then C3, ultimo=1 each cycle, in_ready constantly 1.
- S change mid-word: accept S=10 32'h01020304, switch S to 01 after one cycle → still 01,02,03,04 and internoS=10 throughout.
- enb stall: during 32'hA1B2C3D4, drop enb for 3 cycles after B2 → salida holds B2, contador holds 1 and in_ready=0 during the stall; C3,D4 follow after enb returns.
